// File: rtl/labeling_pkg.sv
// labeling_pkg: shared label types, merge request record and merger FSM states.
`default_nettype none

package labeling_pkg;

  localparam int LABEL_WIDTH = 6;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIND_A  = 3'd1,
    FIND_B  = 3'd2,
    LINK    = 3'd3,
    FLATTEN = 3'd4,
    DONE    = 3'd5
  } merger_state_t;

  typedef struct packed {
    label_t a;
    label_t b;
  } merge_req_t;

endpackage

`default_nettype wire

// File: rtl/merge_fifo.sv
// merge_fifo: synchronous FIFO of merge requests with flush, full/empty flags.
`default_nettype none

module merge_fifo
  import labeling_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  merge_req_t push_data,
  input  logic       pop,
  output merge_req_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  merge_req_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/label_merger.sv
// label_merger: union-find equivalence table for connected-component labels,
// flattened at frame end and read back through a registered resolve port.
`default_nettype none

module label_merger
  import labeling_pkg::*;
#(
  parameter int LABEL_WIDTH = labeling_pkg::LABEL_WIDTH,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic [LABEL_WIDTH-1:0] resolve_label,
  output logic [LABEL_WIDTH-1:0] resolved_label,
  output logic                   table_ready,
  output logic                   busy,
  output logic                   merge_overflow
);

  localparam int NUM_LABELS = 2 ** LABEL_WIDTH;

  label_t        parent [NUM_LABELS];
  merger_state_t state;
  label_t        a_reg;
  label_t        b_reg;
  label_t        idx;
  label_t        max_label;
  logic          frame_end_pending;

  merge_req_t    fifo_in;
  merge_req_t    fifo_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          push_req;
  logic          push_accept;

  logic          tbl_we;
  label_t        tbl_widx;
  label_t        tbl_wdata;

  assign fifo_in.a   = merge_a;
  assign fifo_in.b   = merge_b;
  assign fifo_pop    = (state == IDLE) && !fifo_empty && !frame_start;
  assign push_req    = merge_labels && !frame_start && (state != FLATTEN) && (state != DONE);
  assign push_accept = push_req && (!fifo_full || fifo_pop);

  merge_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (push_req),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // LINK attaches the larger root under the smaller one, keeping parent[i] <= i.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = '0;
    tbl_wdata = '0;
    case (state)
      LINK: begin
        if (a_reg != b_reg) begin
          tbl_we    = 1'b1;
          tbl_widx  = (a_reg > b_reg) ? a_reg : b_reg;
          tbl_wdata = (a_reg > b_reg) ? b_reg : a_reg;
        end
      end
      FLATTEN: begin
        tbl_we    = 1'b1;
        tbl_widx  = idx;
        tbl_wdata = parent[parent[idx]];
      end
      default: ;
    endcase
  end

  // The new-label write is issued last so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LABELS; i++) parent[i] <= label_t'(i);
    end else if (frame_start) begin
      for (int i = 0; i < NUM_LABELS; i++) parent[i] <= label_t'(i);
    end else begin
      if (tbl_we && (tbl_widx != '0)) parent[tbl_widx] <= tbl_wdata;
      if (new_label_valid && (new_label_value != '0)) parent[new_label_value] <= new_label_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      a_reg             <= '0;
      b_reg             <= '0;
      idx               <= '0;
      max_label         <= '0;
      frame_end_pending <= 1'b0;
      merge_overflow    <= 1'b0;
    end else if (frame_start) begin
      state             <= IDLE;
      a_reg             <= '0;
      b_reg             <= '0;
      idx               <= '0;
      max_label         <= '0;
      frame_end_pending <= 1'b0;
      merge_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            a_reg <= fifo_out.a;
            b_reg <= fifo_out.b;
            state <= FIND_A;
          end else if (frame_end_pending) begin
            frame_end_pending <= 1'b0;
            idx               <= label_t'(1);
            state             <= (max_label == '0) ? DONE : FLATTEN;
          end
        end
        FIND_A: begin
          if (parent[a_reg] == a_reg) state <= FIND_B;
          else                        a_reg <= parent[a_reg];
        end
        FIND_B: begin
          if (parent[b_reg] == b_reg) state <= LINK;
          else                        b_reg <= parent[b_reg];
        end
        LINK: state <= IDLE;
        FLATTEN: begin
          if (idx == max_label) state <= DONE;
          else                  idx   <= idx + 1'b1;
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      if (frame_end) frame_end_pending <= 1'b1;
      if (new_label_valid && (new_label_value > max_label)) max_label <= new_label_value;
      if (merge_labels && !push_accept) merge_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resolved_label <= '0;
    else        resolved_label <= parent[resolve_label];
  end

  assign table_ready = (state == DONE);
  assign busy        = !fifo_empty || ((state != IDLE) && (state != DONE)) || frame_end_pending;

endmodule

`default_nettype wire

// File: tb/tb_label_merger.sv
// tb_label_merger: directed self-checking bench for label_merger.
`default_nettype none

module tb_label_merger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       frame_end;
  logic       new_label_valid;
  logic [5:0] new_label_value;
  logic       merge_labels;
  logic [5:0] merge_a;
  logic [5:0] merge_b;
  logic [5:0] resolve_label;
  logic [5:0] resolved_label;
  logic       table_ready;
  logic       busy;
  logic       merge_overflow;

  int total = 0;
  int bad   = 0;

  label_merger #(
    .LABEL_WIDTH (6),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .new_label_valid (new_label_valid),
    .new_label_value (new_label_value),
    .merge_labels    (merge_labels),
    .merge_a         (merge_a),
    .merge_b         (merge_b),
    .resolve_label   (resolve_label),
    .resolved_label  (resolved_label),
    .table_ready     (table_ready),
    .busy            (busy),
    .merge_overflow  (merge_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic add_label(input int v);
    new_label_valid = 1'b1;
    new_label_value = 6'(v);
    tick();
    new_label_valid = 1'b0;
  endtask

  task automatic push_merge(input int a, input int b);
    merge_labels = 1'b1;
    merge_a      = 6'(a);
    merge_b      = 6'(b);
    tick();
    merge_labels = 1'b0;
  endtask

  task automatic end_frame;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!table_ready && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic resolve_chk(input string tag, input int k, input int exp);
    resolve_label = 6'(k);
    tick();
    check(tag, resolved_label, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int low_busy;
    int wrong;

    rst_n           = 1'b0;
    frame_start     = 1'b0;
    frame_end       = 1'b0;
    new_label_valid = 1'b0;
    new_label_value = '0;
    merge_labels    = 1'b0;
    merge_a         = '0;
    merge_b         = '0;
    resolve_label   = '0;
    #12;
    check("rst_resolved", resolved_label, 0);
    check("rst_ready", table_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", merge_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // No merges: flatten of 3 entries
    pulse_start();
    for (int i = 1; i <= 3; i++) add_label(i);
    end_frame();
    check("nm_busy_pending", busy, 1);
    wait_ready(50, n);
    check("nm_latency", n, 4);
    check("nm_ready", table_ready, 1);
    check("nm_busy_done", busy, 0);
    resolve_chk("nm_r1", 1, 1);
    resolve_chk("nm_r2", 2, 2);
    resolve_chk("nm_r3", 3, 3);
    resolve_chk("nm_r0", 0, 0);

    // Chain of merges
    pulse_start();
    check("ch_ready_clr", table_ready, 0);
    for (int i = 1; i <= 4; i++) add_label(i);
    push_merge(3, 4);
    push_merge(2, 3);
    push_merge(1, 2);
    end_frame();
    wait_ready(100, n);
    check("ch_ready", table_ready, 1);
    resolve_chk("ch_r4", 4, 1);
    resolve_chk("ch_r3", 3, 1);
    resolve_chk("ch_r2", 2, 1);
    resolve_chk("ch_r1", 1, 1);

    // Indirect roots
    pulse_start();
    for (int i = 1; i <= 5; i++) add_label(i);
    push_merge(2, 5);
    push_merge(1, 4);
    push_merge(4, 5);
    end_frame();
    wait_ready(100, n);
    check("ind_ready", table_ready, 1);
    resolve_chk("ind_r5", 5, 1);
    resolve_chk("ind_r4", 4, 1);
    resolve_chk("ind_r2", 2, 1);
    resolve_chk("ind_r3", 3, 3);

    // Overflow: 12 back-to-back merges, only the last finds the FIFO full
    pulse_start();
    for (int i = 1; i <= 28; i++) add_label(i);
    check("ov_clear", merge_overflow, 0);
    for (int i = 1; i <= 12; i++) push_merge(i, i + 16);
    check("ov_set", merge_overflow, 1);
    end_frame();
    wait_ready(300, n);
    check("ov_ready", table_ready, 1);
    resolve_chk("ov_r17", 17, 1);
    resolve_chk("ov_r27", 27, 11);
    resolve_chk("ov_r28_dropped", 28, 28);
    resolve_chk("ov_r12_dropped", 12, 12);
    pulse_start();
    check("ov_cleared", merge_overflow, 0);

    // frame_end with merges still queued
    for (int i = 1; i <= 6; i++) add_label(i);
    push_merge(1, 2);
    push_merge(3, 4);
    push_merge(5, 6);
    end_frame();
    low_busy = 0;
    n = 0;
    while (!table_ready && n < 100) begin
      if (!busy) low_busy++;
      tick();
      n++;
    end
    check("q_busy_high", low_busy, 0);
    check("q_ready", table_ready, 1);
    resolve_chk("q_r2", 2, 1);
    resolve_chk("q_r4", 4, 3);
    resolve_chk("q_r6", 6, 5);
    resolve_chk("q_r5", 5, 5);

    // frame_start while a walk is in FIND_A
    pulse_start();
    for (int i = 1; i <= 3; i++) add_label(i);
    push_merge(1, 2);
    repeat (6) tick();
    push_merge(2, 3);
    tick();
    check("fa_busy", busy, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fa_busy_clr", busy, 0);
    check("fa_ready_clr", table_ready, 0);
    wrong = 0;
    for (int k = 0; k < 64; k++) begin
      resolve_label = 6'(k);
      tick();
      if (resolved_label != 6'(k)) wrong++;
    end
    check("fa_table_clr", wrong, 0);

    // Reset mid-FLATTEN, with overflow raised by a merge during FLATTEN
    pulse_start();
    for (int i = 1; i <= 20; i++) add_label(i);
    end_frame();
    tick();
    tick();
    push_merge(1, 2);
    check("fl_ovf", merge_overflow, 1);
    check("fl_busy", busy, 1);
    check("fl_resolved_pre", resolved_label, 63);
    rst_n = 1'b0;
    #1;
    check("ar_resolved", resolved_label, 0);
    check("ar_ready", table_ready, 0);
    check("ar_busy", busy, 0);
    check("ar_ovf", merge_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
